// File: rtl/quadra_seq_ctrl.sv
// quadra_seq_ctrl: sequencer for y = (c*x2 + b)*x2 + a over one shared multiplier,
// with valid/ready handshakes on both the operand and the result side.
module quadra_seq_ctrl #(
    parameter int X1_W = 7,
    parameter int X2_W = 16,
    parameter int D_W  = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [X1_W+X2_W-1:0] in_x,
    output logic [X1_W-1:0]      lut_x1,
    input  logic [D_W-1:0]       lut_a,
    input  logic [D_W-1:0]       lut_b,
    input  logic [D_W-1:0]       lut_c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [D_W-1:0]       out_y,
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, LOOKUP, MUL1, ADD1, MUL2, ADD2, HOLD} state_t;
    state_t state, nxt;
    logic [X2_W-1:0] x2_r;
    logic signed [D_W-1:0] a_r, b_r, c_r, p_r, s_r, mul_op;
    logic signed [D_W+X2_W:0] prod;
    logic accept;
    function automatic logic [D_W-1:0] sat(input logic [D_W-1:0] x, input logic [D_W-1:0] y);
        logic [D_W:0] sum;
        sum = {x[D_W-1], x} + {y[D_W-1], y};
        return sum[D_W] == sum[D_W-1] ? sum[D_W-1:0] : {sum[D_W], {(D_W-1){~sum[D_W]}}};
    endfunction
    assign accept = state == IDLE && in_valid && in_ready;
    assign busy   = state != IDLE;
    // single multiplier: x2 is zero-extended so the product is signed*unsigned
    assign mul_op = state == MUL1 ? c_r : s_r;
    assign prod   = mul_op * $signed({1'b0, x2_r});
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? LOOKUP : IDLE;
            LOOKUP:  nxt = MUL1;
            MUL1:    nxt = ADD1;
            ADD1:    nxt = MUL2;
            MUL2:    nxt = ADD2;
            ADD2:    nxt = HOLD;
            HOLD:    nxt = out_ready ? IDLE : HOLD;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= '0;
            lut_x1    <= '0;
            x2_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= '0;
            p_r       <= '0;
            s_r       <= '0;
        end else begin
            state     <= nxt;
            in_ready  <= nxt == IDLE;
            out_valid <= nxt == HOLD;
            if (accept) begin
                lut_x1 <= in_x[X1_W+X2_W-1:X2_W];
                x2_r   <= in_x[X2_W-1:0];
            end
            if (state == LOOKUP) begin
                a_r <= lut_a;
                b_r <= lut_b;
                c_r <= lut_c;
            end
            if (state == MUL1 || state == MUL2) p_r <= D_W'(prod >>> X2_W);
            if (state == ADD1) s_r <= sat(p_r, b_r);
            if (state == ADD2) out_y <= sat(p_r, a_r);
        end
    end
endmodule

// File: tb/tb_quadra_seq_ctrl.sv
// tb_quadra_seq_ctrl: randomized and directed checks of quadra_seq_ctrl against an
// arithmetic reference model with a behavioural coefficient LUT.
module tb_quadra_seq_ctrl;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [22:0] in_x = '0;
    logic [6:0]  lut_x1;
    logic [23:0] lut_a, lut_b, lut_c, out_y;
    logic        in_ready, out_valid, busy;
    logic [23:0] ta [128];
    logic [23:0] tb_t [128];
    logic [23:0] tc [128];
    int n_checks = 0, n_fail = 0;

    assign lut_a = ta[lut_x1];
    assign lut_b = tb_t[lut_x1];
    assign lut_c = tc[lut_x1];

    quadra_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .lut_x1(lut_x1), .lut_a(lut_a), .lut_b(lut_b), .lut_c(lut_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic longint sx(input logic [23:0] v);
        return longint'($signed(v));
    endfunction
    function automatic longint fdiv(input longint v);
        longint q = v / 65536;
        if (v < 0 && q * 65536 != v) q = q - 1;
        return q;
    endfunction
    function automatic longint clamp(input longint v);
        return v > 8388607 ? 8388607 : (v < -8388608 ? -8388608 : v);
    endfunction
    function automatic logic [23:0] model(input logic [23:0] a, b, c, input logic [15:0] x2);
        longint s;
        s = clamp(fdiv(sx(c) * longint'(x2)) + sx(b));
        return 24'(clamp(fdiv(s * longint'(x2)) + sx(a)));
    endfunction

    task automatic run_op(input logic [6:0] x1, input logic [15:0] x2, input logic [23:0] exp_y, input int hold);
        int n;
        in_x = {x1, x2};
        in_valid = 1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (n >= 20) begin n_fail++; $display("FAIL accept_timeout: in_ready=%b required 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 0;
        in_x = 23'($urandom);
        out_ready = 1;
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL after_accept: in_ready=%b busy=%b required 0 1", in_ready, busy); end
        n_checks++;
        if (lut_x1 !== x1) begin n_fail++; $display("FAIL lut_x1: got %0d required %0d", lut_x1, x1); end
        n = 0;
        while (out_valid !== 1'b1 && n < 12) begin @(posedge clk); #1; n++; end
        out_ready = 0;
        n_checks++;
        if (n !== 5) begin n_fail++; $display("FAIL latency: out_valid after %0d edges required 5", n); end
        n_checks++;
        if (out_y !== exp_y) begin n_fail++; $display("FAIL result x1=%0d x2=%h: out_y=%h required %h", x1, x2, out_y, exp_y); end
        repeat (hold) begin
            in_valid = 1'($urandom);
            in_x = 23'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_y !== exp_y || in_ready !== 1'b0 || lut_x1 !== x1)
                begin n_fail++; $display("FAIL hold: valid=%b y=%h rdy=%b x1=%0d required 1 %h 0 %0d", out_valid, out_y, in_ready, lut_x1, exp_y, x1); end
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready); end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (in_ready !== 0 || out_valid !== 0 || out_y !== 0 || lut_x1 !== 0 || busy !== 0)
            begin n_fail++; $display("FAIL reset_state: rdy=%b vld=%b y=%h x1=%0d busy=%b required all 0", in_ready, out_valid, out_y, lut_x1, busy); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        n_checks++;
        if (in_ready !== 0) begin n_fail++; $display("FAIL ready_before_edge: in_ready=%b required 0", in_ready); end
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1) begin n_fail++; $display("FAIL ready_after_edge: in_ready=%b required 1", in_ready); end
    endtask

    task automatic test_directed();
        ta[5] = 24'h000100; tb_t[5] = 24'h000200; tc[5] = 24'h000400;
        ta[6] = 24'h000000; tb_t[6] = 24'h000000; tc[6] = 24'hFFFC00;
        ta[7] = 24'h7FFFFF; tb_t[7] = 24'h7FFFFF; tc[7] = 24'h000000;
        ta[8] = 24'h800000; tb_t[8] = 24'h800000; tc[8] = 24'h000000;
        run_op(7'd5, 16'h8000, 24'h000300, 0);
        run_op(7'd6, 16'h8000, 24'hFFFF00, 0);
        run_op(7'd7, 16'hFFFF, 24'h7FFFFF, 0);
        run_op(7'd8, 16'hFFFF, 24'h800000, 0);
        run_op(7'd5, 16'h0000, 24'h000100, 0);
    endtask

    task automatic test_backpressure();
        run_op(7'd5, 16'h8000, 24'h000300, 5);
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_q[$];
        int acc_t[$];
        int sent = 0, got = 0;
        logic acc;
        in_x = 23'($urandom);
        in_valid = 1;
        out_ready = 1;
        for (int t = 0; t < 60 && got < 3; t++) begin
            acc = in_valid && in_ready === 1'b1;
            if (out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_spurious: out_y=%h with nothing pending", out_y); end
                else if (out_y !== exp_q[0]) begin n_fail++; $display("FAIL b2b_result %0d: out_y=%h required %h", got, out_y, exp_q[0]); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            if (acc) begin
                exp_q.push_back(model(ta[in_x[22:16]], tb_t[in_x[22:16]], tc[in_x[22:16]], in_x[15:0]));
                acc_t.push_back(t);
            end
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent == 3) in_valid = 0; else in_x = 23'($urandom);
            end
        end
        in_valid = 0;
        out_ready = 0;
        n_checks++;
        if (got !== 3 || acc_t.size() !== 3) begin n_fail++; $display("FAIL b2b_count: results=%0d accepts=%0d required 3 3", got, acc_t.size()); end
        else begin
            n_checks++;
            if (acc_t[1] - acc_t[0] !== 7 || acc_t[2] - acc_t[1] !== 7)
                begin n_fail++; $display("FAIL b2b_spacing: gaps %0d %0d required 7 7", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        ta[9] = 24'h000123; tb_t[9] = 24'h055555; tc[9] = 24'h3AAAAA;
        in_x = {7'd5, 16'h8000};
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        #1;
        n_checks++;
        if (out_valid !== 0 || in_ready !== 0 || busy !== 0 || out_y !== 0 || lut_x1 !== 0)
            begin n_fail++; $display("FAIL mid_reset: vld=%b rdy=%b busy=%b y=%h x1=%0d required all 0", out_valid, in_ready, busy, out_y, lut_x1); end
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 0 || out_valid !== 0) begin n_fail++; $display("FAIL mid_reset_held: rdy=%b vld=%b required 0 0", in_ready, out_valid); end
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 0) begin n_fail++; $display("FAIL stale_valid cycle %0d: out_valid=%b required 0", i, out_valid); end
        end
        run_op(7'd9, 16'h0000, 24'h000123, 0);
    endtask

    task automatic test_random();
        logic [6:0] x1;
        logic [15:0] x2;
        for (int i = 0; i < 25; i++) begin
            x1 = 7'($urandom);
            x2 = ($urandom % 4 == 0) ? 16'h0 : 16'($urandom);
            run_op(x1, x2, model(ta[x1], tb_t[x1], tc[x1], x2), $urandom_range(0, 3));
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            ta[i] = 24'($urandom);
            tb_t[i] = 24'($urandom);
            tc[i] = 24'($urandom);
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
